// File: rtl/keypad_emulator.sv
// keypad_emulator
//   Passive end of a 4x4 matrix keypad row/column scan interface. A scanner
//   drives a (normally one-hot) row pattern; this block answers on col for the
//   key currently being "pressed". Key presses arrive as commands and are played
//   out as press-bounce, hold, release-bounce and gap phases on a 1 ms tick.
//
// Build option
//   KEYPAD_EMU_BOUNCE_EN  defined: contact chatter (PRESS_B / REL_B phases driven
//                         by an 8-bit LFSR) is built in.
//                         undefined: clean IDLE -> HOLD -> GAP -> IDLE sequence,
//                         no LFSR; BOUNCE_MS and LFSR_SEED have no effect.
//
// Handshake
//   cmd_ready is high exactly while the block is idle. A command transfers on a
//   clk edge where cmd_valid & cmd_ready; cmd_valid while busy is simply not
//   taken, and the command stays pending on the source side.
//
// Ports
//   clk          in   system clock
//   reset_n      in   asynchronous active-low reset
//   row[3:0]     in   row drive from scanner (any value legal)
//   col[3:0]     out  column sense, combinational from row
//   cmd_valid    in   command present
//   cmd_ready    out  idle / command accepted when cmd_valid & cmd_ready
//   cmd_key[3:0] in   key index {row[1:0], col[1:0]}
//   cmd_hold_ms  in   hold duration in ticks (0 behaves as 1)
//   contact      out  internal switch contact state
//   busy         out  command in progress
//   done         out  one-clk pulse on the first idle clk after a command
//   state_dbg    out  current FSM state encoding
module keypad_emulator #(
  parameter int         TICK_COUNT = 48_000,
  parameter int         BOUNCE_MS  = 5,
  parameter int         GAP_MS     = 10,
  parameter logic [7:0] LFSR_SEED  = 8'hA5
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [3:0] row,
  output logic [3:0] col,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [3:0] cmd_key,
  input  logic [7:0] cmd_hold_ms,
  output logic       contact,
  output logic       busy,
  output logic       done,
  output logic [2:0] state_dbg
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_PRESS_B = 3'd1,
    S_HOLD    = 3'd2,
    S_REL_B   = 3'd3,
    S_GAP     = 3'd4
  } state_e;

`ifdef KEYPAD_EMU_BOUNCE_EN
  localparam bit BOUNCE_EN_C = 1'b1;
`else
  localparam bit BOUNCE_EN_C = 1'b0;
`endif
  // A zero-length bounce phase is the same as no bounce phase at all.
  localparam bit HAS_BOUNCE = BOUNCE_EN_C && (BOUNCE_MS != 0);

  localparam int                DIV_W      = (TICK_COUNT > 1) ? $clog2(TICK_COUNT) : 1;
  localparam logic [DIV_W-1:0]  DIV_LAST   = DIV_W'(TICK_COUNT - 1);
  localparam logic [7:0]        BOUNCE_DUR = 8'(BOUNCE_MS);
  // GAP always lasts at least one tick so IDLE is never re-entered without a tick.
  localparam logic [7:0]        GAP_DUR    = 8'((GAP_MS == 0) ? 1 : GAP_MS);

  state_e           state_q, state_d;
  logic [DIV_W-1:0] div_q, div_d;
  logic [7:0]       ph_q, ph_d;
  logic [3:0]       key_q, key_d;
  logic [7:0]       hold_q, hold_d;
  logic             contact_q, contact_d;
  logic             done_q, done_d;
  logic [7:0]       dur;
  logic             tick;
  logic             phase_last;
  logic [7:0]       ph_inc;

`ifdef KEYPAD_EMU_BOUNCE_EN
  logic [7:0] lfsr_q, lfsr_d, lfsr_next;
  // Fibonacci LFSR, taps 8,6,5,4 (bits 7,5,4,3), shifting towards the MSB.
  assign lfsr_next = {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
`else
  logic unused_cfg;
  assign unused_cfg = ^LFSR_SEED;
`endif

  assign tick       = (div_q == DIV_LAST);
  assign ph_inc     = (ph_q == 8'hFF) ? ph_q : ph_q + 8'd1;
  assign phase_last = (({1'b0, ph_q} + 9'd1) == {1'b0, dur});

  // Duration of the phase currently being timed.
  always_comb begin
    dur = hold_q;
    case (state_q)
      S_PRESS_B: dur = BOUNCE_DUR;
      S_REL_B:   dur = BOUNCE_DUR;
      S_GAP:     dur = GAP_DUR;
      default:   dur = hold_q;
    endcase
  end

  always_comb begin
    state_d   = state_q;
    div_d     = tick ? '0 : div_q + DIV_W'(1);
    ph_d      = ph_q;
    key_d     = key_q;
    hold_d    = hold_q;
    contact_d = contact_q;
    done_d    = 1'b0;
`ifdef KEYPAD_EMU_BOUNCE_EN
    lfsr_d    = lfsr_q;
`endif
    case (state_q)
      S_IDLE: begin
        contact_d = 1'b0;
        if (cmd_valid) begin
          // Accept overrides any tick in this clk and restarts the divider.
          key_d  = cmd_key;
          hold_d = (cmd_hold_ms == 8'd0) ? 8'd1 : cmd_hold_ms;
          div_d  = '0;
          ph_d   = '0;
          if (HAS_BOUNCE) begin
            state_d = S_PRESS_B;
          end else begin
            state_d   = S_HOLD;
            contact_d = 1'b1;
          end
        end
      end
`ifdef KEYPAD_EMU_BOUNCE_EN
      S_PRESS_B: begin
        if (tick) begin
          contact_d = lfsr_q[0];
          lfsr_d    = lfsr_next;
          if (phase_last) begin
            state_d   = S_HOLD;
            contact_d = 1'b1;
            ph_d      = '0;
          end else begin
            ph_d = ph_inc;
          end
        end
      end
      S_REL_B: begin
        if (tick) begin
          contact_d = lfsr_q[0];
          lfsr_d    = lfsr_next;
          if (phase_last) begin
            state_d   = S_GAP;
            contact_d = 1'b0;
            ph_d      = '0;
          end else begin
            ph_d = ph_inc;
          end
        end
      end
`endif
      S_HOLD: begin
        contact_d = 1'b1;
        if (tick) begin
          if (phase_last) begin
            ph_d = '0;
            if (HAS_BOUNCE) begin
              state_d = S_REL_B;
            end else begin
              state_d   = S_GAP;
              contact_d = 1'b0;
            end
          end else begin
            ph_d = ph_inc;
          end
        end
      end
      S_GAP: begin
        contact_d = 1'b0;
        if (tick) begin
          if (phase_last) begin
            state_d = S_IDLE;
            done_d  = 1'b1;
            ph_d    = '0;
          end else begin
            ph_d = ph_inc;
          end
        end
      end
      default: begin
        state_d   = S_IDLE;
        contact_d = 1'b0;
        ph_d      = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= S_IDLE;
      div_q     <= '0;
      ph_q      <= '0;
      key_q     <= '0;
      hold_q    <= '0;
      contact_q <= 1'b0;
      done_q    <= 1'b0;
`ifdef KEYPAD_EMU_BOUNCE_EN
      lfsr_q    <= LFSR_SEED;
`endif
    end else begin
      state_q   <= state_d;
      div_q     <= div_d;
      ph_q      <= ph_d;
      key_q     <= key_d;
      hold_q    <= hold_d;
      contact_q <= contact_d;
      done_q    <= done_d;
`ifdef KEYPAD_EMU_BOUNCE_EN
      lfsr_q    <= lfsr_d;
`endif
    end
  end

  // Column answer follows row combinationally; extra driven rows are harmless.
  assign col       = (contact_q && row[key_q[3:2]]) ? (4'b0001 << key_q[1:0]) : 4'b0000;
  assign contact   = contact_q;
  assign busy      = (state_q != S_IDLE);
  assign cmd_ready = (state_q == S_IDLE);
  assign done      = done_q;
  assign state_dbg = state_q;

endmodule
